gfx_render_arbiter: RTL and testbench

Shares the single-issue graphics render pipeline (pixel write / texture read, 4-cycle IDLE-FETCH-PROCESS-OUTPUT engine) between N_REQ requesters. Selects one request round-robin and drives the pipeline command bus, holding it stable until render_ready. It then returns the pipeline's RGB result to the winning requester over a valid/ready response channel. A watchdog aborts operations whose render_ready never arrives.

---
 rtl/gfx_arb_pkg.sv | 26 ++
 rtl/gfx_rr_picker.sv | 35 +++
 rtl/gfx_render_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_gfx_render_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_arb_pkg.sv
// Shared types and constants for the graphics render-pipeline arbiter.
package gfx_arb_pkg;

  localparam int RGB_W   = 24;
  localparam int COORD_W = 6;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } arb_state_e;

  // One pipeline command as captured from the winning requester.
  typedef struct packed {
    logic [RGB_W-1:0]   rgb;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [1:0]         mode;
    logic               op;
  } gfx_cmd_t;

endpackage

// File: rtl/gfx_rr_picker.sv
// Combinational round-robin picker: first valid request at or after the
// pointer, wrapping modulo N_REQ. Kept free of state so other schedulers
// can reuse it.
module gfx_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any_valid
);

  logic [IDX_W-1:0] w_pos;

  // Scan from the pointer and take the first asserted request.
  always_comb begin
    o_grant     = '0;
    o_idx       = '0;
    o_any_valid = 1'b0;
    w_pos       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_pos = IDX_W'((int'(i_rr_ptr) + i) % N_REQ);
      if (!o_any_valid && i_req_valid[w_pos]) begin
        o_any_valid    = 1'b1;
        o_idx          = w_pos;
        o_grant[w_pos] = 1'b1;
      end else begin
        o_any_valid = o_any_valid;
      end
    end
  end

endmodule

// File: rtl/gfx_render_arbiter.sv
// Arbiter sharing the single-issue render pipeline among N_REQ requesters.
// Grants one request at a time (round-robin), holds the command on the
// pipeline bus until render_ready, returns the result on a valid/ready
// response channel and aborts operations that never complete.
// Optional build macro GFX_ARB_PRIORITY_EN: requester 0 gets strict priority.
module gfx_render_arbiter
  import gfx_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int RECOVER_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [RGB_W*N_REQ-1:0]     req_rgb,
  input  logic [COORD_W*N_REQ-1:0]   req_x,
  input  logic [COORD_W*N_REQ-1:0]   req_y,
  input  logic [2*N_REQ-1:0]         req_mode,
  input  logic [N_REQ-1:0]           req_op,
  output logic [7:0]                 pipe_pixel_r,
  output logic [7:0]                 pipe_pixel_g,
  output logic [7:0]                 pipe_pixel_b,
  output logic [COORD_W-1:0]         pipe_coord_x,
  output logic [COORD_W-1:0]         pipe_coord_y,
  output logic [1:0]                 pipe_render_mode,
  output logic                       pipe_pixel_write,
  output logic                       pipe_texture_read,
  input  logic [7:0]                 pipe_out_r,
  input  logic [7:0]                 pipe_out_g,
  input  logic [7:0]                 pipe_out_b,
  input  logic                       pipe_render_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [RGB_W-1:0]           rsp_rgb,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int CNT_MAX = (TIMEOUT_CYC > RECOVER_CYC) ? TIMEOUT_CYC : RECOVER_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic [IDX_W-1:0]  r_rr_ptr;
  gfx_cmd_t          r_cmd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_abort;
  logic [IDX_W-1:0]  r_rsp_id;
  logic [RGB_W-1:0]  r_rsp_rgb;
  logic              r_rsp_err;

  gfx_cmd_t          w_cmd_arr [N_REQ];
  logic [N_REQ-1:0]  w_pick_valid;
  logic [N_REQ-1:0]  w_pick_grant;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic              w_prio_hit;
  logic [N_REQ-1:0]  w_win_onehot;
  logic [IDX_W-1:0]  w_win_idx;
  logic              w_win_any;
  logic [IDX_W-1:0]  w_ptr_next;
  logic              w_grant;
  logic              w_at_timeout;
  logic              w_rec_done;

  // Unpack the flat request buses into one command per requester.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_cmd_arr[gi] = {req_rgb[gi*RGB_W +: RGB_W],
                            req_x[gi*COORD_W +: COORD_W],
                            req_y[gi*COORD_W +: COORD_W],
                            req_mode[gi*2 +: 2],
                            req_op[gi]};
  end

`ifdef GFX_ARB_PRIORITY_EN
  // Requester 0 bypasses the rotation; the others rotate among themselves.
  assign w_prio_hit   = req_valid[0];
  assign w_pick_valid = {req_valid[N_REQ-1:1], 1'b0};
`else
  assign w_prio_hit   = 1'b0;
  assign w_pick_valid = req_valid;
`endif

  gfx_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req_valid (w_pick_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_pick_grant),
    .o_idx       (w_pick_idx),
    .o_any_valid (w_pick_any)
  );

  assign w_win_onehot = w_prio_hit ? N_REQ'(1) : w_pick_grant;
  assign w_win_idx    = w_prio_hit ? IDX_W'(0) : w_pick_idx;
  assign w_win_any    = w_prio_hit | w_pick_any;
  assign w_ptr_next   = (w_win_idx == IDX_W'(N_REQ - 1)) ? IDX_W'(0) : (w_win_idx + IDX_W'(1));
  assign w_at_timeout = (r_state == ISSUE) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_rec_done   = (r_cnt == CNT_W'(RECOVER_CYC - 1));

  // Next-state decode and the single-cycle grant strobe.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_any) begin
          w_grant      = 1'b1;
          w_state_next = ISSUE;
        end else begin
          w_state_next = IDLE;
        end
      end
      ISSUE: begin
        if (pipe_render_ready || w_at_timeout) begin
          w_state_next = RESP;
        end else begin
          w_state_next = ISSUE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_next = r_abort ? RECOVER : IDLE;
        end else begin
          w_state_next = RESP;
        end
      end
      RECOVER: begin
        if (w_rec_done) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = RECOVER;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, command capture, watchdog and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_cmd     <= '0;
      r_cnt     <= '0;
      r_abort   <= 1'b0;
      r_rsp_id  <= '0;
      r_rsp_rgb <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_cmd    <= w_cmd_arr[w_win_idx];
            r_rsp_id <= w_win_idx;
            r_cnt    <= '0;
            if (!w_prio_hit) begin
              r_rr_ptr <= w_ptr_next;
            end
          end
        end
        ISSUE: begin
          if (pipe_render_ready) begin
            r_rsp_rgb <= {pipe_out_r, pipe_out_g, pipe_out_b};
            r_rsp_err <= 1'b0;
          end else if (w_at_timeout) begin
            r_rsp_rgb <= '0;
            r_rsp_err <= 1'b1;
            r_abort   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_cnt <= '0;
          end
        end
        RECOVER: begin
          if (w_rec_done) begin
            r_abort <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Grant is only visible in IDLE; strobes drop in the render_ready or
  // abort cycle so the pipeline never re-samples a finished command.
  assign req_ready         = w_grant ? w_win_onehot : '0;
  assign pipe_pixel_write  = (r_state == ISSUE) && (r_cmd.op == OP_WRITE) &&
                             !pipe_render_ready && !w_at_timeout;
  assign pipe_texture_read = (r_state == ISSUE) && (r_cmd.op == OP_READ) &&
                             !pipe_render_ready && !w_at_timeout;
  assign pipe_pixel_r      = r_cmd.rgb[23:16];
  assign pipe_pixel_g      = r_cmd.rgb[15:8];
  assign pipe_pixel_b      = r_cmd.rgb[7:0];
  assign pipe_coord_x      = r_cmd.x;
  assign pipe_coord_y      = r_cmd.y;
  assign pipe_render_mode  = r_cmd.mode;
  assign rsp_valid         = (r_state == RESP);
  assign rsp_id            = r_rsp_id;
  assign rsp_rgb           = r_rsp_rgb;
  assign rsp_err           = r_rsp_err;
  assign busy              = (r_state != IDLE);

endmodule

// File: tb/tb_gfx_render_arbiter.sv
// Scoreboard bench for gfx_render_arbiter: a stimulus process plays
// requesters and the pipeline and pushes expected responses; a monitor
// process drives rsp_ready and checks every presented response.
module tb_gfx_render_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int RC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_op;
  logic [24*N-1:0]   req_rgb;
  logic [6*N-1:0]    req_x, req_y;
  logic [2*N-1:0]    req_mode;
  logic [7:0]        pipe_pixel_r, pipe_pixel_g, pipe_pixel_b;
  logic [5:0]        pipe_coord_x, pipe_coord_y;
  logic [1:0]        pipe_render_mode;
  logic              pipe_pixel_write, pipe_texture_read;
  logic [7:0]        pipe_out_r, pipe_out_g, pipe_out_b;
  logic              pipe_render_ready;
  logic              rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0]        rsp_id;
  logic [23:0]       rsp_rgb;

  logic [23:0] p_rgb  [N];
  logic [5:0]  p_x    [N];
  logic [5:0]  p_y    [N];
  logic [1:0]  p_mode [N];
  logic        p_op   [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_rgb[24*i +: 24] = p_rgb[i];
      req_x[6*i +: 6]     = p_x[i];
      req_y[6*i +: 6]     = p_y[i];
      req_mode[2*i +: 2]  = p_mode[i];
      req_op[i]           = p_op[i];
    end
  end

  gfx_render_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO), .RECOVER_CYC(RC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rgb(req_rgb), .req_x(req_x), .req_y(req_y), .req_mode(req_mode), .req_op(req_op),
    .pipe_pixel_r(pipe_pixel_r), .pipe_pixel_g(pipe_pixel_g), .pipe_pixel_b(pipe_pixel_b),
    .pipe_coord_x(pipe_coord_x), .pipe_coord_y(pipe_coord_y), .pipe_render_mode(pipe_render_mode),
    .pipe_pixel_write(pipe_pixel_write), .pipe_texture_read(pipe_texture_read),
    .pipe_out_r(pipe_out_r), .pipe_out_g(pipe_out_g), .pipe_out_b(pipe_out_b),
    .pipe_render_ready(pipe_render_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_rgb(rsp_rgb), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [23:0] rgb; logic err; } exp_t;
  exp_t q[$];

  int   n_tests = 0, n_fail = 0;
  int   m_ptr = 0;
  bit   have_prev = 1'b0;
  int   last_hs = 0;
  logic last_err = 1'b0;
  int   bp_left = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference arbitration: first valid at/after the pointer, modulo N.
  function automatic int model_pick(input logic [N-1:0] v, input int ptr, output int nptr);
    int g = -1;
    nptr = ptr;
`ifdef GFX_ARB_PRIORITY_EN
    if (v[0]) return 0;
    v[0] = 1'b0;
`endif
    for (int i = 0; i < N; i++)
      if (g < 0 && v[(ptr + i) % N]) g = (ptr + i) % N;
    if (g >= 0) nptr = (g + 1) % N;
    return g;
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      p_rgb[i]  = 24'($urandom());
      p_x[i]    = 6'($urandom());
      p_y[i]    = 6'($urandom());
      p_mode[i] = 2'($urandom());
      p_op[i]   = 1'($urandom());
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_pipe_cmd"}, {pipe_pixel_r, pipe_pixel_g, pipe_pixel_b},  32'd0);
    chk({tag, "_pipe_xym"}, {pipe_coord_x, pipe_coord_y, pipe_render_mode}, 32'd0);
    chk({tag, "_strobes"}, {pipe_pixel_write, pipe_texture_read}, 32'd0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_id, rsp_rgb}, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; pipe_render_ready = 1'b0;
    @(negedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    m_ptr = 0; q.delete(); have_prev = 1'b0;
  endtask

  // One transaction: wait for the grant, play the pipeline for `lat` issue
  // cycles (0 = never answer), optionally pulse rst in issue cycle rst_at.
  task automatic run_txn(input logic [N-1:0] v, input int lat, input int rst_at);
    int g, nptr;
    bit got = 1'b0;
    logic [23:0] c_rgb; logic [5:0] c_x, c_y; logic [1:0] c_mode; logic c_op;
    for (int w = 0; w < 200 && !got; w++) begin
      @(negedge clk);
      req_valid = v;
      pipe_render_ready = ($urandom_range(0, 3) == 0);
      pipe_out_r = 8'($urandom()); pipe_out_g = 8'($urandom()); pipe_out_b = 8'($urandom());
      #1;
      if (req_ready !== '0) got = 1'b1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL grant_wait: actual no grant required grant for pattern %b", v);
      return;
    end
    g = model_pick(v, m_ptr, nptr);
    chk("grant_onehot", 32'(req_ready), 32'(1) << g);
    chk("grant_after_rsp", q.size(), 32'd0);
    if (have_prev) chk("grant_cycle", cyc, last_hs + 1 + (last_err ? RC : 0));
    m_ptr = nptr; have_prev = 1'b1;
    c_rgb = p_rgb[g]; c_x = p_x[g]; c_y = p_y[g]; c_mode = p_mode[g]; c_op = p_op[g];
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      pipe_render_ready = (k == lat);
      pipe_out_r = 8'($urandom()); pipe_out_g = 8'($urandom()); pipe_out_b = 8'($urandom());
      if (k == rst_at) rst = 1'b1;
      #1;
      chk("issue_write", 32'(pipe_pixel_write), 32'(k != lat && k < TO && !c_op));
      chk("issue_read", 32'(pipe_texture_read), 32'(k != lat && k < TO && c_op));
      chk("issue_cmd", {pipe_pixel_r, pipe_pixel_g, pipe_pixel_b}, 32'(c_rgb));
      chk("issue_xym", {pipe_coord_x, pipe_coord_y, pipe_render_mode}, {c_x, c_y, c_mode});
      chk("issue_flags", {rsp_valid, busy, req_ready}, {1'b0, 1'b1, 4'b0000});
      if (k == rst_at) begin
        @(negedge clk);
        rst = 1'b0; req_valid = '0; pipe_render_ready = 1'b0;
        #1;
        chk_zero("midrst");
        m_ptr = 0; q.delete(); have_prev = 1'b0;
        return;
      end
      if (k == lat) begin
        q.push_back('{g, {pipe_out_r, pipe_out_g, pipe_out_b}, 1'b0});
        break;
      end
      if (k == TO) q.push_back('{g, 24'h000000, 1'b1});
    end
    @(negedge clk);
    pipe_render_ready = 1'b1;
    #1;
    chk("rsp_latency", {rsp_valid, busy, req_ready}, {1'b1, 1'b1, 4'b0000});
  endtask

  // Monitor: random backpressure plus check of every presented response.
  initial begin
    exp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bp_left > 0 && rsp_valid === 1'b1) begin
        rsp_ready = 1'b0;
        bp_left--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      #2;
      if (rsp_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rsp_unexpected: actual rsp_valid=1 id=%0d required no response", rsp_id);
        end else begin
          chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
          chk("rsp_rgb", 32'(rsp_rgb), 32'(q[0].rgb));
          chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
          if (rsp_ready) begin
            e = q.pop_front();
            last_hs = cyc;
            last_err = e.err;
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    int lat;
    logic [N-1:0] v;
    rst = 1'b1; req_valid = '0; pipe_render_ready = 1'b0;
    pipe_out_r = 8'h00; pipe_out_g = 8'h00; pipe_out_b = 8'h00;
    for (int i = 0; i < N; i++) begin
      p_rgb[i] = 24'h0; p_x[i] = 6'h0; p_y[i] = 6'h0; p_mode[i] = 2'd0; p_op[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    do_reset();

    // Single pixel write from requester 2.
    rand_payload();
    p_rgb[2] = 24'h123456; p_x[2] = 6'd3; p_y[2] = 6'd5; p_mode[2] = 2'd0; p_op[2] = 1'b0;
    run_txn(4'b0100, 4, 0);

    // Fairness from reset with everyone valid.
    do_reset();
    for (int t = 0; t < 8; t++) begin
      rand_payload();
      run_txn(4'b1111, 4, 0);
    end

    // Texture read from requester 1.
    rand_payload();
    p_op[1] = 1'b1; p_mode[1] = 2'd1;
    run_txn(4'b0010, 4, 0);

    // Pipeline never answers: abort, then recovery gap before next grant.
    rand_payload();
    run_txn(4'b1000, 0, 0);

    // Backpressure, then reset in the middle of an issue.
    bp_left = 10;
    rand_payload();
    run_txn(4'b0001, 3, 0);
    rand_payload();
    run_txn(4'b0110, 4, 3);
    rand_payload();
    run_txn(4'b1111, 4, 0);

    // Requesters 0 and 3 competing, then 3 alone.
    for (int t = 0; t < 6; t++) begin
      rand_payload();
      run_txn(4'b1001, $urandom_range(1, 6), 0);
    end
    rand_payload();
    run_txn(4'b1000, 2, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      rand_payload();
      v = 4'($urandom_range(1, 15));
      lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 10);
      if ($urandom_range(0, 5) == 0) bp_left = $urandom_range(1, 12);
      run_txn(v, lat, 0);
    end

    // Drain the last response.
    req_valid = '0;
    for (int w = 0; w < 100 && q.size() != 0; w++) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: actual %0d responses pending required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
